// File: rtl/vreg_pkg.sv
// Shared types and sizes for the vector register write arbiter.
package vreg_pkg;

    localparam int VREG_NUM   = 4;
    localparam int VREG_ELEMS = 16;
    localparam int VREG_BITS  = 256;

    typedef struct packed {
        logic [1:0] rnum;
        logic [3:0] elem;
    } vreg_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vreg_rr_pick.sv
// Two-requester round-robin picker: when both request, the pointer picks the winner.
module vreg_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
        else              gnt = req;
    end

endmodule

// File: rtl/vreg_write_arbiter.sv
// Shares the vector_regs element and full-register write ports among two burst clients and one full-write client.
// Optional stall watchdog is compiled in with VREG_ARB_TIMEOUT_EN.
module vreg_write_arbiter
    import vreg_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            es_valid,
    output logic [1:0]            es_ready,
    input  logic [1:0][1:0]       es_reg,
    input  logic [1:0][WIDTH-1:0] es_data,
    input  logic [1:0]            es_last,
    input  logic                  fw_valid,
    output logic                  fw_ready,
    input  logic [1:0]            fw_reg,
    input  logic [VREG_BITS-1:0]  fw_data,
    output logic                  we,
    output logic [5:0]            write_addr,
    output logic [WIDTH-1:0]      write_data,
    output logic                  full_we,
    output logic [VREG_BITS-1:0]  full_write_data,
    output logic [1:0]            grant,
    output logic                  burst_done,
    output logic                  timeout_err,
    output arb_state_t            dbg_state
);

    arb_state_t state;
    vreg_addr_t addr_q;
    logic       rr_ptr;
    logic       fw_won_last;
    logic [1:0] reg_q;
    logic [3:0] idx;
    logic [1:0] pick;
    logic       owner;
    logic       fw_take;
    logic       beat;
    logic       burst_end;
    logic       stall_abort;

    vreg_rr_pick u_pick (
        .req (es_valid),
        .ptr (rr_ptr),
        .gnt (pick)
    );

    // Handshake: a transfer happens on a cycle where valid and ready are both 1;
    // ready never waits on the same-cycle transfer and a held valid is not dropped by us.
    assign owner     = grant[1];
    assign fw_take   = (state == IDLE) && fw_valid && (!fw_won_last || es_valid == 2'b00);
    assign fw_ready  = fw_take;
    assign es_ready  = (state == BURST) ? grant : 2'b00;
    assign beat      = (state == BURST) && es_valid[owner];
    assign burst_end = beat && (es_last[owner] || idx == 4'(VREG_ELEMS - 1));
    assign write_addr = addr_q;
    assign dbg_state  = state;

`ifdef VREG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;

    assign stall_abort = (state == BURST) && !es_valid[owner] &&
                         (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == BURST && !es_valid[owner] && !stall_abort) stall_cnt <= stall_cnt + 1'b1;
            else                                                    stall_cnt <= '0;
            if (stall_abort) timeout_err <= 1'b1;
        end
    end
`else
    assign stall_abort = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr_q          <= '0;
            rr_ptr          <= 1'b0;
            fw_won_last     <= 1'b0;
            reg_q           <= '0;
            idx             <= '0;
            grant           <= '0;
            we              <= 1'b0;
            write_data      <= '0;
            full_we         <= 1'b0;
            full_write_data <= '0;
            burst_done      <= 1'b0;
        end else begin
            we         <= 1'b0;
            full_we    <= 1'b0;
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    // fw_won_last makes full writes and element grants take turns under contention.
                    if (fw_take) begin
                        full_we         <= 1'b1;
                        addr_q          <= '{rnum: fw_reg, elem: 4'd0};
                        full_write_data <= fw_data;
                        fw_won_last     <= 1'b1;
                    end else if (|es_valid) begin
                        grant       <= pick;
                        reg_q       <= es_reg[pick[1]];
                        idx         <= '0;
                        fw_won_last <= 1'b0;
                        state       <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        we         <= 1'b1;
                        addr_q     <= '{rnum: reg_q, elem: idx};
                        write_data <= es_data[owner];
                        if (!burst_end) idx <= idx + 4'd1;
                    end
                    if (burst_end || stall_abort) begin
                        state      <= IDLE;
                        burst_done <= 1'b1;
                        rr_ptr     <= ~owner;
                        grant      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// Directed bench for vreg_write_arbiter: cycle-vector table plus multi-cycle burst, stall and reset sequences.
module tb_vreg_write_arbiter;
    import vreg_pkg::*;

    localparam int W = 16;
    localparam logic [255:0] D0 = 256'h123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0;
    localparam logic [255:0] D1 = 256'hA5A5_0F0F_3C3C_9696_1111_2222_4444_8888_DEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           es_valid;
    logic [1:0]           es_ready;
    logic [1:0][1:0]      es_reg;
    logic [1:0][W-1:0]    es_data;
    logic [1:0]           es_last;
    logic                 fw_valid;
    logic                 fw_ready;
    logic [1:0]           fw_reg;
    logic [255:0]         fw_data;
    logic                 we;
    logic [5:0]           write_addr;
    logic [W-1:0]         write_data;
    logic                 full_we;
    logic [255:0]         full_write_data;
    logic [1:0]           grant;
    logic                 burst_done;
    logic                 timeout_err;
    arb_state_t           dbg_state;

    int checks = 0;
    int errors = 0;

    vreg_write_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .es_valid(es_valid), .es_ready(es_ready), .es_reg(es_reg), .es_data(es_data), .es_last(es_last),
        .fw_valid(fw_valid), .fw_ready(fw_ready), .fw_reg(fw_reg), .fw_data(fw_data),
        .we(we), .write_addr(write_addr), .write_data(write_data),
        .full_we(full_we), .full_write_data(full_write_data),
        .grant(grant), .burst_done(burst_done), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (we && full_we) begin
                errors++;
                $display("FAIL exclusive_strobe got we=%b full_we=%b want not both", we, full_we);
            end
        end
    end

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  last;
        logic [1:0]  r0, r1;
        logic [15:0] d0, d1;
        logic        fv;
        logic [1:0]  fr;
        logic        fsel;
        logic [1:0]  x_rdy;
        logic        x_frdy;
        logic        x_we;
        logic [5:0]  x_addr;
        logic [15:0] x_data;
        logic        x_fwe;
        logic        x_done;
        logic [1:0]  x_grant;
    } vec_t;

    vec_t vecs[$];

    // checking tasks
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pre_chk(input string tag, input logic [1:0] xr, input logic xfr);
        chk({tag, " es_ready"}, 256'(es_ready), 256'(xr));
        chk({tag, " fw_ready"}, 256'(fw_ready), 256'(xfr));
    endtask

    task automatic post_chk(input string tag, input logic xwe, input logic [5:0] xa,
                            input logic [15:0] xd, input logic xdone, input logic [1:0] xg);
        chk({tag, " we"}, 256'(we), 256'(xwe));
        chk({tag, " full_we"}, 256'(full_we), 256'(1'b0));
        chk({tag, " burst_done"}, 256'(burst_done), 256'(xdone));
        chk({tag, " grant"}, 256'(grant), 256'(xg));
        if (xwe) begin
            chk({tag, " write_addr"}, 256'(write_addr), 256'(xa));
            chk({tag, " write_data"}, 256'(write_data), 256'(xd));
        end
    endtask

    // driver tasks
    task automatic drive(input logic [1:0] v, input logic [1:0] last, input logic [1:0] r0, input logic [1:0] r1,
                         input logic [15:0] d0, input logic [15:0] d1, input logic fv, input logic [1:0] fr,
                         input logic [255:0] fd);
        es_valid   = v;
        es_last    = last;
        es_reg[0]  = r0;
        es_reg[1]  = r1;
        es_data[0] = d0;
        es_data[1] = d1;
        fw_valid   = fv;
        fw_reg     = fr;
        fw_data    = fd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [1:0] v, input logic [1:0] last, input logic [1:0] r0, input logic [1:0] r1,
                       input logic [15:0] d0, input logic [15:0] d1, input logic fv, input logic [1:0] fr,
                       input logic fsel, input logic [1:0] xr, input logic xfr, input logic xwe,
                       input logic [5:0] xa, input logic [15:0] xd, input logic xfwe, input logic xdone,
                       input logic [1:0] xg);
        vec_t t;
        t.v = v; t.last = last; t.r0 = r0; t.r1 = r1; t.d0 = d0; t.d1 = d1;
        t.fv = fv; t.fr = fr; t.fsel = fsel;
        t.x_rdy = xr; t.x_frdy = xfr; t.x_we = xwe; t.x_addr = xa; t.x_data = xd;
        t.x_fwe = xfwe; t.x_done = xdone; t.x_grant = xg;
        vecs.push_back(t);
    endtask

    initial begin
        int bad_we;
        int dones;
        logic [255:0] fd;

        drive(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 2'd0, '0);

        // cycle table: full write, short burst (es_reg changes ignored), then full/element contention
        //   v      last   r0  r1  d0        d1        fv  fr  fs  rdy    frdy we  addr   data      fwe done grant
        add(2'b00, 2'b00, 2'd0, 2'd0, 16'h0000, 16'h0000, 1, 2'd0, 0, 2'b00, 1, 0, 6'h00, 16'h0000, 1, 0, 2'b00);
        add(2'b01, 2'b00, 2'd1, 2'd0, 16'h0000, 16'h0000, 0, 2'd0, 0, 2'b00, 0, 0, 6'h00, 16'h0000, 0, 0, 2'b01);
        add(2'b01, 2'b00, 2'd2, 2'd0, 16'hF00D, 16'h0000, 0, 2'd0, 0, 2'b01, 0, 1, 6'h10, 16'hF00D, 0, 0, 2'b01);
        add(2'b01, 2'b00, 2'd2, 2'd0, 16'hBEEF, 16'h0000, 0, 2'd0, 0, 2'b01, 0, 1, 6'h11, 16'hBEEF, 0, 0, 2'b01);
        add(2'b01, 2'b01, 2'd3, 2'd0, 16'hCAFE, 16'h0000, 0, 2'd0, 0, 2'b01, 0, 1, 6'h12, 16'hCAFE, 0, 1, 2'b00);
        add(2'b00, 2'b00, 2'd0, 2'd0, 16'h0000, 16'h0000, 0, 2'd0, 0, 2'b00, 0, 0, 6'h00, 16'h0000, 0, 0, 2'b00);
        add(2'b11, 2'b11, 2'd0, 2'd3, 16'hB000, 16'hA001, 1, 2'd2, 1, 2'b00, 1, 0, 6'h20, 16'h0000, 1, 0, 2'b00);
        add(2'b11, 2'b11, 2'd0, 2'd3, 16'hB000, 16'hA001, 1, 2'd2, 1, 2'b00, 0, 0, 6'h00, 16'h0000, 0, 0, 2'b10);
        add(2'b11, 2'b11, 2'd0, 2'd3, 16'hB000, 16'hA001, 1, 2'd2, 1, 2'b10, 0, 1, 6'h30, 16'hA001, 0, 1, 2'b00);
        add(2'b11, 2'b11, 2'd0, 2'd3, 16'hB000, 16'hA001, 1, 2'd2, 1, 2'b00, 1, 0, 6'h20, 16'h0000, 1, 0, 2'b00);
        add(2'b11, 2'b11, 2'd0, 2'd3, 16'hB000, 16'hA001, 1, 2'd2, 1, 2'b00, 0, 0, 6'h00, 16'h0000, 0, 0, 2'b01);
        add(2'b11, 2'b11, 2'd0, 2'd3, 16'hB000, 16'hA001, 1, 2'd2, 1, 2'b01, 0, 1, 6'h00, 16'hB000, 0, 1, 2'b00);
        add(2'b11, 2'b11, 2'd0, 2'd3, 16'hB000, 16'hA001, 1, 2'd2, 1, 2'b00, 1, 0, 6'h20, 16'h0000, 1, 0, 2'b00);

        // reset state
        #1;
        chk("reset we", 256'(we), 256'(1'b0));
        chk("reset full_we", 256'(full_we), 256'(1'b0));
        chk("reset write_addr", 256'(write_addr), 256'(6'h00));
        chk("reset grant", 256'(grant), 256'(2'b00));
        chk("reset burst_done", 256'(burst_done), 256'(1'b0));
        chk("reset timeout_err", 256'(timeout_err), 256'(1'b0));
        chk("reset state", 256'(dbg_state), 256'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            fd = vecs[i].fsel ? D1 : D0;
            drive(vecs[i].v, vecs[i].last, vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1,
                  vecs[i].fv, vecs[i].fr, fd);
            #1;
            pre_chk($sformatf("vec%0d", i), vecs[i].x_rdy, vecs[i].x_frdy);
            tick();
            chk($sformatf("vec%0d we", i), 256'(we), 256'(vecs[i].x_we));
            chk($sformatf("vec%0d full_we", i), 256'(full_we), 256'(vecs[i].x_fwe));
            chk($sformatf("vec%0d burst_done", i), 256'(burst_done), 256'(vecs[i].x_done));
            chk($sformatf("vec%0d grant", i), 256'(grant), 256'(vecs[i].x_grant));
            if (vecs[i].x_we || vecs[i].x_fwe)
                chk($sformatf("vec%0d write_addr", i), 256'(write_addr), 256'(vecs[i].x_addr));
            if (vecs[i].x_we)
                chk($sformatf("vec%0d write_data", i), 256'(write_data), 256'(vecs[i].x_data));
            if (vecs[i].x_fwe)
                chk($sformatf("vec%0d full_write_data", i), full_write_data, fd);
        end

        // client 1, 17 beats without es_last: burst closes at idx 15, 17th beat re-granted to idx 0
        drive(2'b10, 2'b00, 2'd0, 2'd3, 16'h0, 16'h0, 1'b0, 2'd0, '0);
        #1; pre_chk("long grant", 2'b00, 1'b0);
        tick(); post_chk("long grant", 1'b0, 6'h00, 16'h0, 1'b0, 2'b10);
        for (int i = 0; i < 16; i++) begin
            drive(2'b10, 2'b00, 2'd0, 2'd1, 16'h0, 16'(16'h0100 + i), 1'b0, 2'd0, '0);
            #1; pre_chk($sformatf("long beat%0d", i), 2'b10, 1'b0);
            tick();
            post_chk($sformatf("long beat%0d", i), 1'b1, 6'(6'h30 + i), 16'(16'h0100 + i),
                     (i == 15), (i == 15) ? 2'b00 : 2'b10);
        end
        drive(2'b10, 2'b00, 2'd0, 2'd3, 16'h0, 16'h0110, 1'b0, 2'd0, '0);
        #1; pre_chk("beat17 grant", 2'b00, 1'b0);
        tick(); post_chk("beat17 grant", 1'b0, 6'h00, 16'h0, 1'b0, 2'b10);
        #1; pre_chk("beat17", 2'b10, 1'b0);
        tick(); post_chk("beat17", 1'b1, 6'h30, 16'h0110, 1'b0, 2'b10);

        // owner stalls for 100 cycles at idx 1
        drive(2'b00, 2'b00, 2'd0, 2'd3, 16'h0, 16'h0, 1'b0, 2'd0, '0);
        bad_we = 0;
        dones  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (we) bad_we++;
            if (burst_done) dones++;
        end
        chk("stall we count", 256'(bad_we), 256'(0));
`ifdef VREG_ARB_TIMEOUT_EN
        chk("stall abort pulses", 256'(dones), 256'(1));
        chk("stall timeout_err", 256'(timeout_err), 256'(1'b1));
        chk("stall grant", 256'(grant), 256'(2'b00));
        chk("stall state", 256'(dbg_state), 256'(IDLE));
`else
        chk("stall done count", 256'(dones), 256'(0));
        chk("stall timeout_err", 256'(timeout_err), 256'(1'b0));
        chk("stall grant", 256'(grant), 256'(2'b10));
        chk("stall state", 256'(dbg_state), 256'(BURST));
        drive(2'b10, 2'b10, 2'd0, 2'd0, 16'h0, 16'h0BAD, 1'b0, 2'd0, '0);
        #1; pre_chk("stall resume", 2'b10, 1'b0);
        tick(); post_chk("stall resume", 1'b1, 6'h31, 16'h0BAD, 1'b1, 2'b00);
`endif

        // one-beat burst from client 0 moves the pointer to client 1
        drive(2'b01, 2'b01, 2'd0, 2'd0, 16'h0C01, 16'h0, 1'b0, 2'd0, '0);
        #1; pre_chk("rb grant0", 2'b00, 1'b0);
        tick(); post_chk("rb grant0", 1'b0, 6'h00, 16'h0, 1'b0, 2'b01);
        #1; pre_chk("rb beat0", 2'b01, 1'b0);
        tick(); post_chk("rb beat0", 1'b1, 6'h00, 16'h0C01, 1'b1, 2'b00);

        // both request: client 1 wins, reaches idx 5, then reset mid-burst
        drive(2'b11, 2'b00, 2'd0, 2'd2, 16'h0C02, 16'h0, 1'b0, 2'd0, '0);
        #1; pre_chk("rb grant1", 2'b00, 1'b0);
        tick(); post_chk("rb grant1", 1'b0, 6'h00, 16'h0, 1'b0, 2'b10);
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 2'b00, 2'd0, 2'd0, 16'h0C02, 16'(16'h0D00 + i), 1'b0, 2'd0, '0);
            #1; pre_chk($sformatf("rb beat%0d", i), 2'b10, 1'b0);
            tick();
            post_chk($sformatf("rb beat%0d", i), 1'b1, 6'(6'h20 + i), 16'(16'h0D00 + i), 1'b0, 2'b10);
        end
        #2;
        drive(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 2'd0, '0);
        rst_n = 1'b0;
        #1;
        chk("async rst we", 256'(we), 256'(1'b0));
        chk("async rst write_addr", 256'(write_addr), 256'(6'h00));
        chk("async rst write_data", 256'(write_data), 256'(16'h0));
        chk("async rst full_we", 256'(full_we), 256'(1'b0));
        chk("async rst full_write_data", full_write_data, 256'(0));
        chk("async rst grant", 256'(grant), 256'(2'b00));
        chk("async rst es_ready", 256'(es_ready), 256'(2'b00));
        chk("async rst burst_done", 256'(burst_done), 256'(1'b0));
        chk("async rst timeout_err", 256'(timeout_err), 256'(1'b0));
        chk("async rst state", 256'(dbg_state), 256'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // after reset the pointer favours client 0 and idx restarts at 0
        drive(2'b11, 2'b11, 2'd1, 2'd3, 16'h0E00, 16'h0F00, 1'b0, 2'd0, '0);
        #1; pre_chk("post rst grant", 2'b00, 1'b0);
        tick(); post_chk("post rst grant", 1'b0, 6'h00, 16'h0, 1'b0, 2'b01);
        #1; pre_chk("post rst beat", 2'b01, 1'b0);
        tick(); post_chk("post rst beat", 1'b1, 6'h10, 16'h0E00, 1'b1, 2'b00);

        drive(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 2'd0, '0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
